// File: rtl/ff_stim_check.sv
// ff_stim_check: LFSR stimulus source and cycle-accurate response checker for the ff flip-flop.
// state | meaning -- IDLE: wait start | INIT: DUT held in reset | RUN: vectors applied | DRAIN: last compares | DONE: verdict held
module ff_stim_check #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int unsigned INIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        start,
    output logic        ff_D,
    output logic        ff_E,
    output logic        ff_R_,
    input  logic        ff_Q,
    input  logic        ff_Q_,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] vec_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0]  C_SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] C_INIT_LAST  = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] C_RUN_LAST   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] C_DRAIN_LAST = 16'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [7:0]  r_lfsr;
    logic [7:0]  w_lfsr_step;
    logic        r_exp_q;
    logic        r_ff_d;
    logic        r_ff_e;
    logic        r_ff_r;
    logic [15:0] r_err;
    logic [15:0] r_vec;
    logic        w_enter_init;
    logic        w_apply;
    logic        w_d_nxt;
    logic        w_e_nxt;
    logic        w_r_nxt;
    logic        w_cmp_en;
    logic        w_mismatch;

    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_mismatch  = (ff_Q != r_exp_q) || (ff_Q_ == ff_Q);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_init = 1'b0;
        w_apply      = 1'b0;
        w_cmp_en     = 1'b0;
        w_d_nxt      = 1'b0;
        w_e_nxt      = 1'b0;
        w_r_nxt      = 1'b1;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = S_INIT;
                    w_cnt_nxt    = C_INIT_LAST;
                    w_enter_init = 1'b1;
                end
            end
            S_INIT: begin
                // first INIT cycle is masked: the DUT has not yet seen R_=0
                w_cmp_en = (r_cnt != C_INIT_LAST);
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = C_RUN_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_RUN: begin
                w_cmp_en = 1'b1;
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = C_DRAIN_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_DRAIN: begin
                w_cmp_en = 1'b1;
                if (r_cnt == 16'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // ff_* are registered, so they follow the state being entered
        if (w_state_nxt == S_INIT) begin
            w_r_nxt = 1'b0;
        end else if (w_state_nxt == S_RUN) begin
            w_apply = 1'b1;
            w_d_nxt = r_lfsr[0];
            w_e_nxt = r_lfsr[1];
            w_r_nxt = |r_lfsr[7:5];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_lfsr  <= C_SEED;
            r_exp_q <= 1'b0;
            r_ff_d  <= 1'b0;
            r_ff_e  <= 1'b0;
            r_ff_r  <= 1'b0;
            r_err   <= '0;
            r_vec   <= '0;
        end else begin
            r_ff_d <= w_d_nxt;
            r_ff_e <= w_e_nxt;
            r_ff_r <= w_r_nxt;
            if (w_enter_init) begin
                r_lfsr  <= C_SEED;
                r_exp_q <= 1'b0;
                r_err   <= '0;
                r_vec   <= '0;
            end else begin
                if (!r_ff_r) begin
                    r_exp_q <= 1'b0;
                end else if (r_ff_e) begin
                    r_exp_q <= r_ff_d;
                end
                if (w_apply) begin
                    r_lfsr <= w_lfsr_step;
                    r_vec  <= r_vec + 16'd1;
                end
                if (w_cmp_en && w_mismatch && (r_err != 16'hFFFF)) begin
                    r_err <= r_err + 16'd1;
                end
            end
        end
    end

    assign ff_D      = r_ff_d;
    assign ff_E      = r_ff_e;
    assign ff_R_     = r_ff_r;
    assign busy      = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err == 16'd0);
    assign err_count = r_err;
    assign vec_count = r_vec;

endmodule

// File: tb/tb_ff_stim_check.sv
// Bench for ff_stim_check: behavioural ff with injectable faults, scoreboard of per-run verdicts.
module tb_ff_stim_check;
    typedef struct {
        int t0;
        int lat;
        int err;
        bit pass;
        int vec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start0, start1;
    logic        ffD0, ffE0, ffR0, ffQ0, ffQn0;
    logic        ffD1, ffE1, ffR1, ffQ1, ffQn1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, vec0, err1, vec1;
    logic        q0r = 1'b0;
    logic        q1r = 1'b0;
    int          mode = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    exp_t        m0, m1;
    logic        pd0 = 1'b0;
    logic        pd1 = 1'b0;
    logic [2:0]  wv[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ff_stim_check u_dut0 (
        .clk(clk), .rst_(rst_), .start(start0),
        .ff_D(ffD0), .ff_E(ffE0), .ff_R_(ffR0), .ff_Q(ffQ0), .ff_Q_(ffQn0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0)
    );

    ff_stim_check #(.NUM_VECTORS(1), .LFSR_SEED(8'h00), .INIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_(rst_), .start(start1),
        .ff_D(ffD1), .ff_E(ffE1), .ff_R_(ffR1), .ff_Q(ffQ1), .ff_Q_(ffQn1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .vec_count(vec1)
    );

    // behavioural ff; mode 1 sticks Q at 0, mode 2 ties Q_ to Q
    always @(posedge clk) begin
        if (!ffR0) q0r <= 1'b0;
        else if (ffE0) q0r <= ffD0;
        if (!ffR1) q1r <= 1'b0;
        else if (ffE1) q1r <= ffD1;
    end
    assign ffQ0  = (mode == 1) ? 1'b0 : q0r;
    assign ffQn0 = (mode == 2) ? ffQ0 : ~ffQ0;
    assign ffQ1  = q1r;
    assign ffQn1 = ~q1r;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // mismatches seen with Q stuck at 0: every compare edge where the model holds 1
    function automatic int stuck_err(input logic [7:0] seed, input int n);
        logic [7:0] l;
        logic       q;
        int         s;
        l = (seed == 8'h00) ? 8'h01 : seed;
        q = 1'b0;
        s = 0;
        for (int j = 0; j < n; j++) begin
            if (l[7:5] == 3'b000) q = 1'b0;
            else if (l[1]) q = l[0];
            s += int'(q);
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return s + int'(q);
    endfunction

    task automatic do_start0(input bit push, input int err, input bit ps);
        exp_t e;
        @(negedge clk);
        start0 = 1'b1;
        e.t0 = cyc + 1; e.lat = 260; e.err = err; e.pass = ps; e.vec = 256;
        if (push) sb0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic do_start1();
        exp_t e;
        @(negedge clk);
        start1 = 1'b1;
        e.t0 = cyc + 1; e.lat = 5; e.err = 0; e.pass = 1'b1; e.vec = 1;
        sb1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done0(input int max);
        for (int i = 0; i < max; i++) begin
            if (done0) break;
            @(negedge clk);
        end
        check("wait_done0", done0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_) begin
            check("busy_done_excl0", busy0 & done0, 0);
        end
        if (done0 && !pd0) begin
            if (sb0.size() == 0) begin
                total++; bad++;
                $display("FAIL sb0_unexpected_done actual=1 required=0");
            end else begin
                m0 = sb0.pop_front();
                check("sb0_latency", cyc - m0.t0, m0.lat);
                check("sb0_err", err0, m0.err);
                check("sb0_pass", pass0, m0.pass);
                check("sb0_vec", vec0, m0.vec);
            end
        end
        if (done1 && !pd1) begin
            if (sb1.size() == 0) begin
                total++; bad++;
                $display("FAIL sb1_unexpected_done actual=1 required=0");
            end else begin
                m1 = sb1.pop_front();
                check("sb1_latency", cyc - m1.t0, m1.lat);
                check("sb1_err", err1, m1.err);
                check("sb1_pass", pass1, m1.pass);
                check("sb1_vec", vec1, m1.vec);
            end
        end
        pd0 = done0;
        pd1 = done1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        wv = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b100, 3'b100};
        rst_ = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check("rst_ff_D", ffD0, 0);
        check("rst_ff_E", ffE0, 0);
        check("rst_ff_R_", ffR0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_vec", vec0, 0);
        rst_ = 1'b1;

        do_start0(1'b1, 0, 1'b1);
        wait_done0(300);

        mode = 1;
        do_start0(1'b1, stuck_err(8'hA5, 256), 1'b0);
        wait_done0(300);
        check("stuck_err_nonzero", err0 != 16'd0, 1);

        mode = 2;
        do_start0(1'b1, 259, 1'b0);
        wait_done0(300);

        mode = 0;
        do_start0(1'b0, 0, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (vec0 == 16'd100) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_vec100", hit, 1);
        rst_ = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy0, 0);
        check("midrst_ff_R_", ffR0, 0);
        check("midrst_err", err0, 0);
        check("midrst_vec", vec0, 0);
        check("midrst_done", done0, 0);
        rst_ = 1'b1;
        do_start0(1'b1, 0, 1'b1);
        wait_done0(300);

        do_start0(1'b1, 0, 1'b1);
        repeat (50) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("start_in_run_busy", busy0, 1);
        wait_done0(300);

        for (int r = 0; r < 2; r++) begin
            do_start1();
            for (int k = 0; k < 6; k++) begin
                if (k != 0) @(negedge clk);
                check($sformatf("u1_wave_r%0d_k%0d", r, k), {ffR1, ffE1, ffD1}, wv[k]);
            end
            check($sformatf("u1_done_r%0d", r), done1, 1);
        end

        repeat (3) @(negedge clk);
        check("sb0_empty", sb0.size(), 0);
        check("sb1_empty", sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_stim_check.md
# ff_stim_check

Self-checking stimulus source and response checker for the `ff` flip-flop (ports clk, D, E, R_, Q, Q_). It sits directly upstream and downstream of `ff` in the flip-flop test harness and replaces a scripted driver. It drives pseudo-random D/E/R_ vectors into the DUT, runs a cycle-accurate model of `ff`, compares Q and Q_ against that model every cycle, and reports an error count and a pass/fail verdict.

## Interface
- `NUM_VECTORS`, 256: number of random vectors applied per run; legal range 1..65535.
- `LFSR_SEED`, 8'hA5: LFSR seed loaded on every start. A value of 0 is replaced by 8'h01.
- `INIT_CYCLES`, 2: cycles the DUT is held in reset (R_=0) before vectors start; legal range ≥1.

Ports:
- `clk` in 1: single clock; the same clock drives the DUT.
- `rst_` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle run request. Honoured only in IDLE or DONE.
- `ff_D` out 1: DUT data input.
- `ff_E` out 1: DUT enable.
- `ff_R_` out 1: DUT reset, active-low.
- `ff_Q` in 1: DUT output.
- `ff_Q_` in 1: DUT complement output.
- `busy` out 1: high in INIT, RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: equals done && err_count==0.
- `err_count` out 16: number of mismatching compare cycles; saturates at 16'hFFFF.
- `vec_count` out 16: number of vectors applied in the current or most recent run.

## Operation
- DUT model (`exp_q`) is updated at each clk edge: if ff_R_==0, exp_q←0; else if ff_E==1, exp_q←ff_D; else exp_q holds. R_ has priority over E.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances once per RUN cycle. Vector bit mapping: ff_D=lfsr[0], ff_E=lfsr[1], ff_R_ = (lfsr[7:5]!=3'b000).
- FSM states and transitions:
  - IDLE: go to INIT on start.
  - INIT: go to RUN after INIT_CYCLES cycles.
  - RUN: go to DRAIN after NUM_VECTORS cycles.
  - DRAIN: go to DONE after 2 cycles.
  - DONE: go to INIT on start.
- On entry to INIT: lfsr←seed; err_count, vec_count and exp_q are cleared. During INIT, ff_R_=0, ff_E=0 and ff_D=0.
- RUN: registered outputs present lfsr-derived values; vec_count increments once per applied vector.
- DRAIN and IDLE/DONE outputs: ff_R_=1, ff_E=0, ff_D=0. The DUT holds its state.
- Compare:
  - Active from the 2nd INIT cycle through the last DRAIN cycle.
  - A cycle is a mismatch if ff_Q!=exp_q or ff_Q_!=~ff_Q. Each mismatching cycle increments err_count by 1 (saturating).
  - Compare is masked outside the active window.
- start while busy is ignored. start in DONE restarts with identical seed, so the vector sequence is identical across runs.

## Timing
- Reset values (rst_ low at an edge): state=IDLE, ff_D=0, ff_E=0, ff_R_=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, lfsr=seed, exp_q=0.
- Reset mid-run: at the next edge, everything returns to reset values; the run is abandoned with no verdict.
- Pipeline per vector:
  - Vector registered onto ff_* at edge n.
  - DUT and exp_q capture it at edge n+1.
  - ff_Q is compared against exp_q and err_count updates at edge n+2.
  - The 2-cycle DRAIN covers the last vector's compare.
- start at edge t0 (IDLE) → busy=1 and ff_R_=0 from t0. First RUN vector appears at t0+INIT_CYCLES. done=1 at t0+INIT_CYCLES+NUM_VECTORS+2.
- busy and done are never high together. done and pass stay stable until start or rst_.
- vec_count saturates only via parameter range; it never wraps.

## Test plan
- Correct behavioural `ff`, default parameters: start → done after 2+256+2=260 cycles, err_count=0, pass=1, vec_count=256.
- DUT with Q stuck at 0: start → done at 260 cycles, err_count>0, pass=0. The first error is reported no earlier than the first vector with E=1, D=1, R_=1.
- DUT with Q_ tied to Q: every active compare cycle mismatches. err_count equals the active-window length (1+256+2=259), pass=0.
- rst_ pulsed low for 1 cycle at vector 100 → next edge: busy=0, ff_R_=0, counters 0. A new start then completes with pass=1.
- NUM_VECTORS=1, LFSR_SEED=0: start → exactly one RUN vector derived from seed 8'h01, done after 5 cycles, pass=1. A second start reproduces identical ff_* waveforms.
- start asserted during RUN: ignored. Run length and results are unchanged.
